// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the CPU / I/O single-port RAM arbiter.
package ram_port_arbiter_pkg;

  localparam int BIT_DATA   = 8;
  localparam int SZB_RAM    = 8;
  localparam int STARVE_W   = 4;
  localparam int STARVE_DEF = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  // Observable arbiter state for checkers.
  typedef struct packed {
    logic                rd_pend;
    logic                owner;
    logic [STARVE_W-1:0] starve_cnt;
  } arb_dbg_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the I/O port asked and was refused.
module arb_starve_cnt #(
  parameter int STARVE = 4,
  parameter int W      = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX = W'(STARVE);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between CPU (fixed priority) and I/O engine,
// with a starvation guard that forces an I/O grant after STARVE refusals.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int BIT    = BIT_DATA,
  parameter int SZB    = SZB_RAM,
  parameter int STARVE = STARVE_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  // Handshake: a request is accepted in any cycle where req=1 and gnt=1;
  // the requester holds we/addr/d stable until then. At most one gnt per cycle.
  input  logic           c_req_i,
  input  logic           c_we_i,
  input  logic [SZB-1:0] c_addr_i,
  input  logic [BIT-1:0] c_d_i,
  output logic           c_gnt_o,
  output logic           c_rvalid_o,
  output logic [BIT-1:0] c_q_o,
  input  logic           i_req_i,
  input  logic           i_we_i,
  input  logic [SZB-1:0] i_addr_i,
  input  logic [BIT-1:0] i_d_i,
  output logic           i_gnt_o,
  output logic           i_rvalid_o,
  output logic [BIT-1:0] i_q_o,
  output logic           ram_we_o,
  output logic [SZB-1:0] ram_addr_o,
  output logic [BIT-1:0] ram_d_o,
  input  logic [BIT-1:0] ram_q_i,
  output arb_dbg_t       dbg_o
);

  logic                force_io;
  logic [STARVE_W-1:0] starve_cnt;

  logic           rd_pend_q, rd_pend_d;
  logic           owner_q, owner_d;
  logic [SZB-1:0] addr_q, addr_d;
  logic [BIT-1:0] d_q, d_d;

  assign c_gnt_o = ~rst_i & c_req_i & ~force_io;
  assign i_gnt_o = ~rst_i & i_req_i & (~c_req_i | force_io);

  arb_starve_cnt #(
    .STARVE (STARVE),
    .W      (STARVE_W)
  ) u_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (i_req_i & ~i_gnt_o),
    .clr_i (~i_req_i | i_gnt_o),
    .cnt_o (starve_cnt),
    .sat_o (force_io)
  );

  // Idle cycles keep the RAM address/data bus at the last granted values.
  always_comb begin
    rd_pend_d  = 1'b0;
    owner_d    = owner_q;
    addr_d     = addr_q;
    d_d        = d_q;
    ram_we_o   = 1'b0;
    ram_addr_o = addr_q;
    ram_d_o    = d_q;
    if (c_gnt_o) begin
      ram_we_o   = c_we_i;
      ram_addr_o = c_addr_i;
      ram_d_o    = c_d_i;
      addr_d     = c_addr_i;
      d_d        = c_d_i;
      if (!c_we_i) begin
        rd_pend_d = 1'b1;
        owner_d   = PORT_CPU;
      end
    end else if (i_gnt_o) begin
      ram_we_o   = i_we_i;
      ram_addr_o = i_addr_i;
      ram_d_o    = i_d_i;
      addr_d     = i_addr_i;
      d_d        = i_d_i;
      if (!i_we_i) begin
        rd_pend_d = 1'b1;
        owner_d   = PORT_IO;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_pend_q <= 1'b0;
      owner_q   <= PORT_CPU;
      addr_q    <= '0;
      d_q       <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      d_q       <= d_d;
    end
  end

  // Read data comes straight from the RAM; rvalid is the only qualifier.
  assign c_rvalid_o = ~rst_i & rd_pend_q & (owner_q == PORT_CPU);
  assign i_rvalid_o = ~rst_i & rd_pend_q & (owner_q == PORT_IO);
  assign c_q_o      = ram_q_i;
  assign i_q_o      = ram_q_i;

  assign dbg_o = '{rd_pend: rd_pend_q, owner: owner_q, starve_cnt: starve_cnt};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model and a behavioural RAM.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int STARVE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       c_req = 0, c_we = 0, i_req = 0, i_we = 0;
  logic [7:0] c_addr = 0, c_d = 0, i_addr = 0, i_d = 0;
  logic       c_gnt, c_rvalid, i_gnt, i_rvalid, ram_we;
  logic [7:0] c_q, i_q, ram_addr, ram_d;
  logic [7:0] ram_q;
  arb_dbg_t   dbg;

  ram_port_arbiter #(.BIT(8), .SZB(8), .STARVE(STARVE)) dut (
    .clk_i(clk), .rst_i(rst),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_d_i(c_d),
    .c_gnt_o(c_gnt), .c_rvalid_o(c_rvalid), .c_q_o(c_q),
    .i_req_i(i_req), .i_we_i(i_we), .i_addr_i(i_addr), .i_d_i(i_d),
    .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid), .i_q_o(i_q),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
    .ram_q_i(ram_q), .dbg_o(dbg)
  );

  // Behavioural synchronous RAM, one cycle read latency.
  logic [7:0] mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] = 8'h00;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  logic [8:0] exp_q [$];          // {port, data} of reads awaiting return
  int         m_starve;           // consecutive refused I/O cycles
  logic [7:0] m_addr, m_d;
  bit         have_pred;
  logic       e_cg, e_ig, e_we, e_cv, e_iv;
  logic [7:0] e_addr, e_d, e_data;
  int         e_starve;
  int         n_checks = 0, n_pass = 0;

  initial for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;

  task automatic clear_model();
    exp_q.delete();
    m_starve  = 0;
    m_addr    = 8'h00;
    m_d       = 8'h00;
    have_pred = 0;
  endtask

  task automatic predict();
    if (rst) begin
      clear_model();
      e_cg = 0; e_ig = 0; e_we = 0; e_addr = 0; e_d = 0;
      e_cv = 0; e_iv = 0; e_data = 0; e_starve = 0;
    end else begin
      // CPU wins unless I/O has already waited STARVE cycles; I/O gets any cycle CPU doesn't.
      e_cg = c_req && (m_starve < STARVE);
      e_ig = i_req && !e_cg;
      e_we   = e_cg ? c_we   : (e_ig ? i_we   : 1'b0);
      e_addr = e_cg ? c_addr : (e_ig ? i_addr : m_addr);
      e_d    = e_cg ? c_d    : (e_ig ? i_d    : m_d);
      e_cv   = (exp_q.size() > 0) && (exp_q[0][8] == 1'b0);
      e_iv   = (exp_q.size() > 0) && (exp_q[0][8] == 1'b1);
      e_data = (exp_q.size() > 0) ? exp_q[0][7:0] : 8'h00;
      e_starve  = m_starve;
      have_pred = 1;
    end
  endtask

  task automatic commit();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (e_cg) begin
      if (c_we) ref_mem[c_addr] = c_d;
      else exp_q.push_back({1'b0, ref_mem[c_addr]});
      m_addr = c_addr; m_d = c_d;
    end else if (e_ig) begin
      if (i_we) ref_mem[i_addr] = i_d;
      else exp_q.push_back({1'b1, ref_mem[i_addr]});
      m_addr = i_addr; m_d = i_d;
    end
    if (i_req && !e_ig) m_starve = (m_starve < STARVE) ? m_starve + 1 : m_starve;
    else m_starve = 0;
    have_pred = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic cr, cw, input logic [7:0] ca, cd,
                       input logic ir, iw, input logic [7:0] ia, id);
    if (have_pred) commit();
    @(negedge clk);
    rst = r;
    c_req = cr; c_we = cw; c_addr = ca; c_d = cd;
    i_req = ir; i_we = iw; i_addr = ia; i_d = id;
    #1;
    predict();
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1, 1, 1, 8'h07, 8'h5A, 1, 1, 8'h08, 8'h6B);
    n_checks++; if (c_gnt !== 1'b0) $display("FAIL reset_c_gnt got=%b exp=0", c_gnt); else n_pass++;
    n_checks++; if (i_gnt !== 1'b0) $display("FAIL reset_i_gnt got=%b exp=0", i_gnt); else n_pass++;
    n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got=%b exp=0", ram_we); else n_pass++;
    n_checks++; if (dbg !== '0) $display("FAIL reset_state got=%h exp=0", dbg); else n_pass++;
    drive(0, 1, 1, 8'h07, 8'h5A, 1, 1, 8'h08, 8'h6B);
    n_checks++; if (c_gnt !== 1'b1) $display("FAIL release_c_gnt got=%b exp=1", c_gnt); else n_pass++;
    n_checks++; if (i_gnt !== 1'b0) $display("FAIL release_i_gnt got=%b exp=0", i_gnt); else n_pass++;
    idle();
  endtask

  task automatic test_write_read();
    idle();
    drive(0, 1, 1, 8'h05, 8'hA5, 0, 0, 8'h00, 8'h00);
    n_checks++; if ({c_gnt, ram_we, ram_addr, ram_d} !== {2'b11, 8'h05, 8'hA5})
      $display("FAIL wr_bus got=%b%b %h %h exp=11 05 a5", c_gnt, ram_we, ram_addr, ram_d); else n_pass++;
    drive(0, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
    n_checks++; if ({c_gnt, ram_we, c_rvalid} !== 3'b100)
      $display("FAIL rd_grant got=%b%b%b exp=100", c_gnt, ram_we, c_rvalid); else n_pass++;
    idle();
    n_checks++; if ({c_rvalid, i_rvalid} !== 2'b10)
      $display("FAIL rd_valid got=%b%b exp=10", c_rvalid, i_rvalid); else n_pass++;
    n_checks++; if (c_q !== 8'hA5) $display("FAIL rd_data got=%h exp=a5", c_q); else n_pass++;
  endtask

  task automatic test_starve();
    idle();
    for (int k = 0; k < 7; k++) begin
      drive(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00);
      n_checks++;
      if ({c_gnt, i_gnt} !== ((k == STARVE) ? 2'b01 : 2'b10))
        $display("FAIL starve_cycle%0d got=%b%b exp=%b", k, c_gnt, i_gnt,
                 (k == STARVE) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_alternate();
    drive(0, 1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        if (k % 2 == 0) drive(0, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
        else            drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
      end else idle();
      if (k > 0) begin
        n_checks++;
        if (k % 2 == 1) begin
          if ({c_rvalid, i_rvalid, c_q} !== {2'b10, 8'h11})
            $display("FAIL alt_cpu%0d got=%b%b %h exp=10 11", k, c_rvalid, i_rvalid, c_q);
          else n_pass++;
        end else begin
          if ({c_rvalid, i_rvalid, i_q} !== {2'b01, 8'h22})
            $display("FAIL alt_io%0d got=%b%b %h exp=01 22", k, c_rvalid, i_rvalid, i_q);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    drive(0, 1, 1, 8'h30, 8'h01, 1, 0, 8'h02, 8'h00);
    drive(0, 1, 1, 8'h31, 8'h02, 1, 0, 8'h02, 8'h00);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
    n_checks++; if ({i_gnt, dbg.starve_cnt} !== {1'b1, 4'd2})
      $display("FAIL inflight_grant got=%b %0d exp=1 2", i_gnt, dbg.starve_cnt); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    #1;
    n_checks++; if ({i_rvalid, i_gnt} !== 2'b00)
      $display("FAIL inflight_in_reset got=%b%b exp=00", i_rvalid, i_gnt); else n_pass++;
    idle();
    n_checks++; if ({i_rvalid, c_rvalid} !== 2'b00)
      $display("FAIL inflight_after got=%b%b exp=00", i_rvalid, c_rvalid); else n_pass++;
    n_checks++; if (dbg.starve_cnt !== 4'd0)
      $display("FAIL inflight_starve got=%0d exp=0", dbg.starve_cnt); else n_pass++;
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 8'h40, 8'h00, 1, 0, 8'h41, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    idle();
    n_checks++; if (dbg.starve_cnt !== 4'd0)
      $display("FAIL starve_reset got=%0d exp=0", dbg.starve_cnt); else n_pass++;
  endtask

  task automatic test_idle_hold();
    drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h9C, 8'h3E);
    for (int k = 0; k < 3; k++) begin
      idle();
      n_checks++;
      if ({ram_we, ram_addr, c_rvalid, i_rvalid} !== {1'b0, 8'h9C, 2'b00})
        $display("FAIL idle%0d got=%b %h %b%b exp=0 9c 00", k, ram_we, ram_addr, c_rvalid, i_rvalid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic cr, cw, ir, iw;
    logic [7:0] ca, cd, ia, id;
    cr = 0; cw = 0; ca = 0; cd = 0; ir = 0; iw = 0; ia = 0; id = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cr || e_cg) begin
        cr = ($urandom_range(0, 99) < 65); cw = $urandom_range(0, 1);
        ca = 8'($urandom_range(0, 15)); cd = 8'($urandom);
      end
      if (!ir || e_ig) begin
        ir = ($urandom_range(0, 99) < 55); iw = $urandom_range(0, 1);
        ia = 8'($urandom_range(0, 15)); id = 8'($urandom);
      end
      drive(0, cr, cw, ca, cd, ir, iw, ia, id);
      n_checks++;
      if ({c_gnt, i_gnt, ram_we, ram_addr, ram_d} !== {e_cg, e_ig, e_we, e_addr, e_d})
        $display("FAIL rnd_bus%0d got=%b%b%b %h %h exp=%b%b%b %h %h", n, c_gnt, i_gnt, ram_we,
                 ram_addr, ram_d, e_cg, e_ig, e_we, e_addr, e_d);
      else n_pass++;
      n_checks++;
      if ({c_rvalid, i_rvalid} !== {e_cv, e_iv})
        $display("FAIL rnd_rvalid%0d got=%b%b exp=%b%b", n, c_rvalid, i_rvalid, e_cv, e_iv);
      else n_pass++;
      if (e_cv || e_iv) begin
        n_checks++;
        if ((e_cv ? c_q : i_q) !== e_data)
          $display("FAIL rnd_data%0d got=%h exp=%h", n, e_cv ? c_q : i_q, e_data);
        else n_pass++;
      end
      n_checks++;
      if (32'(dbg.starve_cnt) !== e_starve)
        $display("FAIL rnd_starve%0d got=%0d exp=%0d", n, dbg.starve_cnt, e_starve);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_read();
    test_starve();
    test_alternate();
    test_reset_in_flight();
    test_idle_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
